// File: rtl/mem_req_mux_n_pkg.sv
// Shared definitions for the N-input host-memory request multiplexer.
// Holds width helpers and build defaults used by mem_req_mux_n and rr_arb_n.
package mem_req_mux_pkg;

    localparam int DEF_DATA_WIDTH     = 512;
    localparam int DEF_ADDR_WIDTH     = 64;
    localparam int DEF_RD_OUTSTANDING = 64;

    // Widest grant index needed for the largest supported input count (16).
    localparam int GNT_IDX_W = 4;
    typedef logic [GNT_IDX_W-1:0] gnt_idx_t;

    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_n.sv
// Round-robin arbiter: first requester at or after the pointer, with wrap.
// A stalled grant is locked until accepted so the winner cannot change.
module rr_arb_n
    import mem_req_mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req_i,
    input  logic                     acc_i,
    output logic                     gnt_vld_o,
    output logic [clog2_min1(N)-1:0] gnt_idx_o
);

    localparam int IW = clog2_min1(N);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] lidx_q, lidx_d;
    logic          lock_q, lock_d;
    logic [IW-1:0] srch_idx;
    logic          srch_vld;
    logic          hold;
    logic [IW:0]   cand;

    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin
        srch_vld = 1'b0;
        srch_idx = '0;
        cand     = '0;
        for (int j = N - 1; j >= 0; j--) begin
            cand = {1'b0, ptr_q} + (IW+1)'(j);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (req_i[cand[IW-1:0]]) begin
                srch_vld = 1'b1;
                srch_idx = cand[IW-1:0];
            end
        end
    end

    assign hold      = lock_q && req_i[lidx_q];
    assign gnt_vld_o = hold || srch_vld;
    assign gnt_idx_o = hold ? lidx_q : srch_idx;

    always_comb begin
        ptr_d  = ptr_q;
        lock_d = 1'b0;
        lidx_d = lidx_q;
        if (acc_i) begin
            if (gnt_idx_o == IW'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_o + IW'(1);
            end
        end else if (gnt_vld_o) begin
            lock_d = 1'b1;
            lidx_d = gnt_idx_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            lock_q <= 1'b0;
            lidx_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            lock_q <= lock_d;
            lidx_q <= lidx_d;
        end
    end

endmodule

// File: rtl/mem_req_mux_n.sv
// N-to-1 host-memory request mux: round-robin write/read arbitration,
// credit-limited reads, in-order return routing. Option: MEM_REQ_MUX_N_RD_ERR_EN.
module mem_req_mux_n
    import mem_req_mux_pkg::*;
#(
    parameter int IN_NUM         = 4,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int MASK_WIDTH     = DATA_WIDTH / 8,
    parameter int RD_OUTSTANDING = DEF_RD_OUTSTANDING,
    parameter int RD_RET_LAT     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [IN_NUM*DATA_WIDTH-1:0]     in_wr_data,
    input  logic [IN_NUM*MASK_WIDTH-1:0]     in_wr_datamask,
    input  logic [IN_NUM*ADDR_WIDTH-1:0]     in_wr_addr,
    output logic [IN_NUM-1:0]                in_wr_cmd_rdy,
    input  logic [IN_NUM-1:0]                in_rd_en,
    input  logic [IN_NUM*ADDR_WIDTH-1:0]     in_rd_addr,
    output logic [IN_NUM-1:0]                in_rd_cmd_rdy,
    output logic [IN_NUM*DATA_WIDTH-1:0]     in_rd_data,
    output logic [IN_NUM-1:0]                in_rd_data_vld,
    input  logic                             wr_cmd_rdy,
    output logic [DATA_WIDTH-1:0]            wr_data,
    output logic [MASK_WIDTH-1:0]            wr_datamask,
    output logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic                             rd_cmd_rdy,
    output logic                             rd_en,
    output logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic [DATA_WIDTH-1:0]            rd_data,
    input  logic                             rd_data_vld,
    output logic [$clog2(RD_OUTSTANDING):0]  rd_outstanding
`ifdef MEM_REQ_MUX_N_RD_ERR_EN
    ,
    output logic                             rd_err
`endif
);

    localparam int IW = clog2_min1(IN_NUM);
    localparam int PW = $clog2(RD_OUTSTANDING);
    localparam int CW = PW + 1;

    logic [IN_NUM-1:0] wr_req;
    logic              wr_gv, wr_acc;
    logic [IW-1:0]     wr_g;
    logic              rd_gv, rd_acc;
    logic [IW-1:0]     rd_g;
    logic              credit_ok;

    always_comb begin
        wr_req = '0;
        for (int i = 0; i < IN_NUM; i++) begin
            wr_req[i] = |in_wr_datamask[i*MASK_WIDTH +: MASK_WIDTH];
        end
    end

    assign wr_acc = wr_gv && wr_cmd_rdy && !rst;

    rr_arb_n #(.N(IN_NUM)) u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (wr_req),
        .acc_i     (wr_acc),
        .gnt_vld_o (wr_gv),
        .gnt_idx_o (wr_g)
    );

    always_comb begin
        wr_data       = '0;
        wr_datamask   = '0;
        wr_addr       = '0;
        in_wr_cmd_rdy = '0;
        if (wr_gv) begin
            wr_data       = in_wr_data[int'(wr_g)*DATA_WIDTH +: DATA_WIDTH];
            wr_datamask   = in_wr_datamask[int'(wr_g)*MASK_WIDTH +: MASK_WIDTH];
            wr_addr       = in_wr_addr[int'(wr_g)*ADDR_WIDTH +: ADDR_WIDTH];
            in_wr_cmd_rdy[wr_g] = wr_cmd_rdy && !rst;
        end
    end

    // Read side: credits bound the order FIFO so it can never overflow.
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [IW-1:0] mem_q [RD_OUTSTANDING];
    logic [IW-1:0] head;
    logic          empty;
    logic          pop;
    logic          ret_vld;
    logic [DATA_WIDTH-1:0] ret_data;

    assign credit_ok = cnt_q < CW'(RD_OUTSTANDING);
    assign rd_acc    = rd_gv && credit_ok && rd_cmd_rdy && !rst;
    assign empty     = cnt_q == '0;
    assign head      = mem_q[rp_q];
    assign pop       = ret_vld && !empty;

    rr_arb_n #(.N(IN_NUM)) u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (in_rd_en),
        .acc_i     (rd_acc),
        .gnt_vld_o (rd_gv),
        .gnt_idx_o (rd_g)
    );

    always_comb begin
        rd_en         = rd_gv && credit_ok && !rst;
        rd_addr       = '0;
        in_rd_cmd_rdy = '0;
        if (rd_gv) begin
            rd_addr = in_rd_addr[int'(rd_g)*ADDR_WIDTH +: ADDR_WIDTH];
            in_rd_cmd_rdy[rd_g] = rd_cmd_rdy && credit_ok && !rst;
        end
    end

    generate
        if (RD_RET_LAT == 0) begin : g_ret_comb
            assign ret_vld  = rd_data_vld;
            assign ret_data = rd_data;
        end else begin : g_ret_pipe
            logic [RD_RET_LAT-1:0] vld_q;
            logic [DATA_WIDTH-1:0] dat_q [RD_RET_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= rd_data_vld;
                    for (int k = 1; k < RD_RET_LAT; k++) begin
                        vld_q[k] <= vld_q[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                dat_q[0] <= rd_data;
                for (int k = 1; k < RD_RET_LAT; k++) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end

            assign ret_vld  = vld_q[RD_RET_LAT-1];
            assign ret_data = dat_q[RD_RET_LAT-1];
        end
    endgenerate

    always_comb begin
        wp_d  = rd_acc ? wp_q + PW'(1) : wp_q;
        rp_d  = pop ? rp_q + PW'(1) : rp_q;
        cnt_d = cnt_q;
        if (rd_acc && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!rd_acc && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc) begin
            mem_q[wp_q] <= rd_g;
        end
    end

    always_comb begin
        in_rd_data     = '0;
        in_rd_data_vld = '0;
        if (pop && !rst) begin
            in_rd_data_vld[head] = 1'b1;
            in_rd_data[int'(head)*DATA_WIDTH +: DATA_WIDTH] = ret_data;
        end
    end

    assign rd_outstanding = cnt_q;

`ifdef MEM_REQ_MUX_N_RD_ERR_EN
    logic err_q;
    logic full;

    assign full = cnt_q == CW'(RD_OUTSTANDING);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((ret_vld && empty) || (rd_acc && full)) begin
            err_q <= 1'b1;
        end
    end

    assign rd_err = err_q;
`endif

endmodule

// File: tb/tb_mem_req_mux_n.sv
// Self-checking bench for mem_req_mux_n: write table, read corner
// sequences, and randomized reads against a queue-based model.
module tb_mem_req_mux_n;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int MW  = DW / 8;
    localparam int RO  = 4;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*DW-1:0]   in_wr_data;
    logic [N*MW-1:0]   in_wr_datamask;
    logic [N*AW-1:0]   in_wr_addr;
    logic [N-1:0]      in_wr_cmd_rdy;
    logic [N-1:0]      in_rd_en;
    logic [N*AW-1:0]   in_rd_addr;
    logic [N-1:0]      in_rd_cmd_rdy;
    logic [N*DW-1:0]   in_rd_data;
    logic [N-1:0]      in_rd_data_vld;
    logic              wr_cmd_rdy;
    logic [DW-1:0]     wr_data;
    logic [MW-1:0]     wr_datamask;
    logic [AW-1:0]     wr_addr;
    logic              rd_cmd_rdy;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              rd_data_vld;
    logic [$clog2(RO):0] rd_outstanding;
`ifdef MEM_REQ_MUX_N_RD_ERR_EN
    logic              rd_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_req_mux_n #(
        .IN_NUM         (N),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .MASK_WIDTH     (MW),
        .RD_OUTSTANDING (RO),
        .RD_RET_LAT     (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_wr_data     (in_wr_data),
        .in_wr_datamask (in_wr_datamask),
        .in_wr_addr     (in_wr_addr),
        .in_wr_cmd_rdy  (in_wr_cmd_rdy),
        .in_rd_en       (in_rd_en),
        .in_rd_addr     (in_rd_addr),
        .in_rd_cmd_rdy  (in_rd_cmd_rdy),
        .in_rd_data     (in_rd_data),
        .in_rd_data_vld (in_rd_data_vld),
        .wr_cmd_rdy     (wr_cmd_rdy),
        .wr_data        (wr_data),
        .wr_datamask    (wr_datamask),
        .wr_addr        (wr_addr),
        .rd_cmd_rdy     (rd_cmd_rdy),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_data_vld    (rd_data_vld),
        .rd_outstanding (rd_outstanding)
`ifdef MEM_REQ_MUX_N_RD_ERR_EN
        ,
        .rd_err         (rd_err)
`endif
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Write table: request bits, host rdy, expected accept one-hot, winner.
    typedef struct {
        logic [N-1:0] req;
        logic         rdy;
        logic [N-1:0] exp_rdy;
        int           idx;
    } wvec_t;

    wvec_t wt [20];

    // Read model: owners of in-flight reads in issue order, host returns.
    typedef struct {
        int unsigned  due;
        logic [DW-1:0] d;
    } ret_t;

    int          q_own [$];
    ret_t        q_ret [$];
    logic [N-1:0] vlog [$];
    int unsigned cyc = 0;
    int          m_ptr = 0;
    int          m_hold = -1;
    int          acc_seen = 0;

    task automatic do_reset();
        in_rd_en    = '0;
        rd_cmd_rdy  = 1'b0;
        rd_data_vld = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_own.delete();
        q_ret.delete();
        m_ptr  = 0;
        m_hold = -1;
        cyc++;
    endtask

    task automatic rd_cycle(input logic [N-1:0] en, input logic rdy,
                            input logic hv, input logic [DW-1:0] hd,
                            output int acc);
        int            g;
        bit            credit;
        bit            ret_now;
        logic [N-1:0]  e_rdy;
        logic [N-1:0]  e_vld;
        logic [N*DW-1:0] e_dat;
        in_rd_en    = en;
        rd_cmd_rdy  = rdy;
        rd_data_vld = hv;
        rd_data     = hd;
        if (hv) q_ret.push_back('{cyc + LAT, hd});
        g = -1;
        if (m_hold >= 0 && en[m_hold]) begin
            g = m_hold;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && en[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        credit = q_own.size() < RO;
        e_rdy = '0;
        if (g >= 0 && credit && rdy) e_rdy[g] = 1'b1;
        ret_now = q_ret.size() > 0 && q_ret[0].due == cyc;
        e_vld = '0;
        e_dat = '0;
        if (ret_now && q_own.size() > 0) begin
            e_vld[q_own[0]] = 1'b1;
            e_dat[q_own[0]*DW +: DW] = q_ret[0].d;
        end
        #4;
        chk("rd_cmd_rdy", in_rd_cmd_rdy, e_rdy);
        chk("rd_en", rd_en, (g >= 0 && credit));
        if (g >= 0 && credit) chk("rd_addr", rd_addr, 16'hA000 + g);
        chk("rd_outstanding", rd_outstanding, q_own.size());
        chk("rd_data_vld_out", in_rd_data_vld, e_vld);
        chk("rd_data_out", in_rd_data, e_dat);
        if (|in_rd_cmd_rdy) acc_seen++;
        if (in_rd_data_vld != '0) vlog.push_back(in_rd_data_vld);
        if (ret_now) begin
            void'(q_ret.pop_front());
            if (q_own.size() > 0) void'(q_own.pop_front());
        end
        acc = -1;
        if (g >= 0 && credit && rdy) begin
            q_own.push_back(g);
            m_ptr  = (g + 1) % N;
            m_hold = -1;
            acc    = g;
        end else begin
            m_hold = g;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        logic [N-1:0] pend;
        wt = '{
            '{4'hF, 1'b1, 4'b0001, 0},
            '{4'hF, 1'b1, 4'b0010, 1},
            '{4'hF, 1'b1, 4'b0100, 2},
            '{4'hF, 1'b1, 4'b1000, 3},
            '{4'hF, 1'b1, 4'b0001, 0},
            '{4'h4, 1'b0, 4'b0000, 2},
            '{4'hC, 1'b0, 4'b0000, 2},
            '{4'hC, 1'b0, 4'b0000, 2},
            '{4'hC, 1'b0, 4'b0000, 2},
            '{4'hC, 1'b0, 4'b0000, 2},
            '{4'hC, 1'b1, 4'b0100, 2},
            '{4'hC, 1'b1, 4'b1000, 3},
            '{4'h0, 1'b1, 4'b0000, N},
            '{4'h4, 1'b0, 4'b0000, 2},
            '{4'h5, 1'b0, 4'b0000, 2},
            '{4'h5, 1'b1, 4'b0100, 2},
            '{4'h1, 1'b1, 4'b0001, 0},
            '{4'hA, 1'b1, 4'b0010, 1},
            '{4'hA, 1'b1, 4'b1000, 3},
            '{4'hA, 1'b1, 4'b0010, 1}
        };
        in_wr_datamask = '0;
        wr_cmd_rdy     = 1'b0;
        in_rd_en       = '0;
        rd_cmd_rdy     = 1'b0;
        rd_data_vld    = 1'b0;
        rd_data        = '0;
        for (int i = 0; i < N; i++) begin
            in_wr_data[i*DW +: DW] = 32'hD0 + i;
            in_wr_addr[i*AW +: AW] = 16'h0100 + i;
            in_rd_addr[i*AW +: AW] = 16'hA000 + i;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #4;
        chk("rst_wr_rdy", in_wr_cmd_rdy, 0);
        chk("rst_rd_rdy", in_rd_cmd_rdy, 0);
        chk("rst_rd_vld", in_rd_data_vld, 0);
        chk("rst_outst", rd_outstanding, 0);
        chk("rst_wr_mask", wr_datamask, 0);
        chk("rst_rd_en", rd_en, 0);
`ifdef MEM_REQ_MUX_N_RD_ERR_EN
        chk("rst_rd_err", rd_err, 0);
`endif
        @(posedge clk);
        #1;

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                in_wr_datamask[i*MW +: MW] = wt[r].req[i] ? 4'hF : 4'h0;
            end
            wr_cmd_rdy = wt[r].rdy;
            #4;
            chk($sformatf("wr_rdy[%0d]", r), in_wr_cmd_rdy, wt[r].exp_rdy);
            chk($sformatf("wr_mask[%0d]", r), wr_datamask,
                (wt[r].idx < N) ? 4'hF : 4'h0);
            if (wt[r].idx < N) begin
                chk($sformatf("wr_addr[%0d]", r), wr_addr, 16'h0100 + wt[r].idx);
                chk($sformatf("wr_data[%0d]", r), wr_data, 32'hD0 + wt[r].idx);
            end
            @(posedge clk);
            #1;
        end
        in_wr_datamask = '0;
        wr_cmd_rdy     = 1'b0;

        // Credit exhaustion, then one return frees exactly one slot.
        acc_seen = 0;
        repeat (6) rd_cycle(4'b0010, 1'b1, 1'b0, '0, g);
        chk("credit_cnt", rd_outstanding, RO);
        chk("credit_accepts", acc_seen, RO);
        chk("credit_rdy_low", in_rd_cmd_rdy, 0);
        acc_seen = 0;
        rd_cycle(4'b0010, 1'b1, 1'b1, 32'hCAFE0001, g);
        repeat (4) rd_cycle(4'b0010, 1'b1, 1'b0, '0, g);
        chk("credit_one_more", acc_seen, 1);

        // In-order return routing to inputs 0,3,1.
        do_reset();
        vlog.delete();
        rd_cycle(4'b1001, 1'b1, 1'b0, '0, g);
        rd_cycle(4'b1000, 1'b1, 1'b0, '0, g);
        rd_cycle(4'b0010, 1'b1, 1'b0, '0, g);
        rd_cycle('0, 1'b0, 1'b1, 32'h1111_0000, g);
        rd_cycle('0, 1'b0, 1'b1, 32'h2222_0000, g);
        rd_cycle('0, 1'b0, 1'b1, 32'h3333_0000, g);
        repeat (3) rd_cycle('0, 1'b0, 1'b0, '0, g);
        chk("order_n", vlog.size(), 3);
        if (vlog.size() == 3) begin
            chk("order_0", vlog[0], 4'b0001);
            chk("order_1", vlog[1], 4'b1000);
            chk("order_2", vlog[2], 4'b0010);
        end

        // Simultaneous accept and pop keeps the count; reset drops in-flight.
        repeat (3) rd_cycle(4'b0100, 1'b1, 1'b0, '0, g);
        rd_cycle('0, 1'b0, 1'b1, 32'h4444_0000, g);
        rd_cycle('0, 1'b0, 1'b0, '0, g);
        rd_cycle(4'b0100, 1'b1, 1'b0, '0, g);
        chk("simul_cnt", rd_outstanding, 3);
        do_reset();
        chk("rst_mid_cnt", rd_outstanding, 0);
        vlog.delete();
        rd_cycle('0, 1'b0, 1'b1, 32'h5555_0000, g);
        repeat (3) rd_cycle('0, 1'b0, 1'b0, '0, g);
        chk("stray_ret_n", vlog.size(), 0);
`ifdef MEM_REQ_MUX_N_RD_ERR_EN
        chk("rd_err_set", rd_err, 1);
        rd_cycle('0, 1'b0, 1'b0, '0, g);
        chk("rd_err_hold", rd_err, 1);
        do_reset();
        chk("rd_err_clr", rd_err, 0);
`endif

        // Randomized reads with persistent requests.
        pend = '0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset();
                pend = '0;
            end
            pend = pend | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            rd_cycle(pend, ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 2) == 0), $urandom, g);
            if (g >= 0) pend[g] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
